// File: rtl/mcpu_soc_audio_dma.sv
// Refill sequencer for the audio sample ring buffer: polls the half/start flags, clears the serviced
// flag, then copies half a buffer of samples from memory into the audio MMIO slots.
// Optional feature macro AUDIO_DMA_SILENCE_EN: after the source runs dry, keep filling with zeros.
module mcpu_soc_audio_dma #(
   parameter int BUF_SIZE      = 16,
   parameter int BUF_ADDR_BITS = 4
) (
   input  logic        clkrst_core_clk,
   input  logic        clkrst_core_rst_n,
   input  logic        cfg_en,
   input  logic        cfg_loop,
   input  logic [31:0] cfg_base,
   input  logic [23:0] cfg_len,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [9:0]  aud_addr,
   output logic [31:0] aud_data_in,
   output logic [31:0] aud_write_mask,
   input  logic [31:0] aud_data_out,
   output logic        busy,
   output logic        done_pulse,
   output logic [15:0] underrun_cnt
);

   localparam int HALF = BUF_SIZE / 2;

   typedef enum logic [2:0] {IDLE, POLL, CLEAR, FETCH, WRITE} state_t;

   state_t                   state, state_nxt;
   logic [31:0]              cur_addr, cur_addr_nxt;
   logic [23:0]              remain, remain_nxt;
   logic [BUF_ADDR_BITS-1:0] slot, slot_nxt, slot_inc;
   logic                     half_hi, half_hi_nxt;
   logic                     exhausted, exhausted_nxt;

   logic        mem_req_nxt, busy_nxt, done_nxt;
   logic [31:0] mem_addr_nxt, aud_data_in_nxt, aud_mask_nxt;
   logic [9:0]  aud_addr_nxt;
   logic [15:0] underrun_nxt;

   logic unused_bits;
   assign unused_bits = &{1'b0, aud_data_out[31:2], cfg_base[1:0]};

   function automatic logic [9:0] slot_addr(input logic hi, input logic [BUF_ADDR_BITS-1:0] s);
      logic [BUF_ADDR_BITS-1:0] idx;
      idx = hi ? s + BUF_ADDR_BITS'(HALF) : s;
      return 10'h200 | 10'(idx);
   endfunction

   always_comb begin
      state_nxt       = state;
      cur_addr_nxt    = cur_addr;
      remain_nxt      = remain;
      slot_nxt        = slot;
      half_hi_nxt     = half_hi;
      exhausted_nxt   = exhausted;
      mem_req_nxt     = 1'b0;
      mem_addr_nxt    = mem_addr;
      aud_addr_nxt    = '0;
      aud_data_in_nxt = '0;
      aud_mask_nxt    = '0;
      done_nxt        = 1'b0;
      underrun_nxt    = underrun_cnt;
      slot_inc        = slot + BUF_ADDR_BITS'(1);
      case (state)
         IDLE: begin
            // A finished non-loop source stays parked until software drops cfg_en to re-arm.
            if (!cfg_en) begin
               exhausted_nxt = 1'b0;
            end else if (cfg_len != 24'd0 && !exhausted) begin
               cur_addr_nxt = {cfg_base[31:2], 2'b00};
               remain_nxt   = cfg_len;
               state_nxt    = POLL;
            end
         end
         POLL: begin
            if (!cfg_en) begin
               state_nxt = IDLE;
            end else if (aud_data_out[1:0] != 2'b00) begin
               // Start-of-buffer wins; the half flag is picked up on the next look.
               half_hi_nxt     = aud_data_out[1];
               aud_data_in_nxt = {30'b0, aud_data_out[1], ~aud_data_out[1]};
               aud_mask_nxt    = {30'b0, aud_data_out[1], ~aud_data_out[1]};
               state_nxt       = CLEAR;
               if (aud_data_out[1:0] == 2'b11 && underrun_cnt != 16'hFFFF)
                  underrun_nxt = underrun_cnt + 16'd1;
            end
         end
         CLEAR: begin
            slot_nxt = '0;
`ifdef AUDIO_DMA_SILENCE_EN
            if (exhausted) begin
               state_nxt    = WRITE;
               aud_addr_nxt = slot_addr(half_hi, '0);
               aud_mask_nxt = '1;
            end else
`endif
            begin
               state_nxt    = FETCH;
               mem_req_nxt  = 1'b1;
               mem_addr_nxt = cur_addr;
            end
         end
         FETCH: begin
            if (mem_ack) begin
               state_nxt       = WRITE;
               aud_addr_nxt    = slot_addr(half_hi, slot);
               aud_data_in_nxt = mem_rdata;
               aud_mask_nxt    = '1;
            end else begin
               mem_req_nxt = 1'b1;
            end
         end
         WRITE: begin
            slot_nxt = slot_inc;
            if (!exhausted) begin
               cur_addr_nxt = cur_addr + 32'd4;
               remain_nxt   = remain - 24'd1;
               if (remain == 24'd1) begin
                  // A zero-length reload would underflow remain, so it counts as exhaustion.
                  if (cfg_loop && cfg_len != 24'd0) begin
                     cur_addr_nxt = {cfg_base[31:2], 2'b00};
                     remain_nxt   = cfg_len;
                  end else begin
                     exhausted_nxt = 1'b1;
                     done_nxt      = 1'b1;
                  end
               end
            end
`ifdef AUDIO_DMA_SILENCE_EN
            if (slot_inc == BUF_ADDR_BITS'(HALF)) begin
               state_nxt = POLL;
            end else if (exhausted_nxt) begin
               state_nxt    = WRITE;
               aud_addr_nxt = slot_addr(half_hi, slot_inc);
               aud_mask_nxt = '1;
            end else begin
               state_nxt    = FETCH;
               mem_req_nxt  = 1'b1;
               mem_addr_nxt = cur_addr_nxt;
            end
`else
            if (exhausted_nxt) begin
               state_nxt = IDLE;
            end else if (slot_inc == BUF_ADDR_BITS'(HALF)) begin
               state_nxt = POLL;
            end else begin
               state_nxt    = FETCH;
               mem_req_nxt  = 1'b1;
               mem_addr_nxt = cur_addr_nxt;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
      if (!clkrst_core_rst_n) begin
         state          <= IDLE;
         cur_addr       <= '0;
         remain         <= '0;
         slot           <= '0;
         half_hi        <= 1'b0;
         exhausted      <= 1'b0;
         mem_req        <= 1'b0;
         mem_addr       <= '0;
         aud_addr       <= '0;
         aud_data_in    <= '0;
         aud_write_mask <= '0;
         busy           <= 1'b0;
         done_pulse     <= 1'b0;
         underrun_cnt   <= '0;
      end else begin
         state          <= state_nxt;
         cur_addr       <= cur_addr_nxt;
         remain         <= remain_nxt;
         slot           <= slot_nxt;
         half_hi        <= half_hi_nxt;
         exhausted      <= exhausted_nxt;
         mem_req        <= mem_req_nxt;
         mem_addr       <= mem_addr_nxt;
         aud_addr       <= aud_addr_nxt;
         aud_data_in    <= aud_data_in_nxt;
         aud_write_mask <= aud_mask_nxt;
         busy           <= busy_nxt;
         done_pulse     <= done_nxt;
         underrun_cnt   <= underrun_nxt;
      end
   end

endmodule

// File: tb/tb_mcpu_soc_audio_dma.sv
// Directed bench for mcpu_soc_audio_dma: memory and audio MMIO models run inside a single per-cycle
// tick so flag clearing, acks and the write log never race the stimulus.
module tb_mcpu_soc_audio_dma;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_en, cfg_loop;
   logic [31:0] cfg_base;
   logic [23:0] cfg_len;
   logic        mem_req, mem_ack;
   logic [31:0] mem_addr, mem_rdata;
   logic [9:0]  aud_addr;
   logic [31:0] aud_data_in, aud_write_mask, aud_data_out;
   logic        busy, done_pulse;
   logic [15:0] underrun_cnt;
   logic [1:0]  status;

   always #5 clk = ~clk;

   assign aud_data_out = (aud_addr == 10'h0) ? {30'b0, status} : 32'h0;

   mcpu_soc_audio_dma #(.BUF_SIZE(16), .BUF_ADDR_BITS(4)) dut (
      .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n),
      .cfg_en(cfg_en), .cfg_loop(cfg_loop), .cfg_base(cfg_base), .cfg_len(cfg_len),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .aud_addr(aud_addr), .aud_data_in(aud_data_in), .aud_write_mask(aud_write_mask),
      .aud_data_out(aud_data_out), .busy(busy), .done_pulse(done_pulse), .underrun_cnt(underrun_cnt)
   );

   typedef struct {
      logic [1:0]  st;
      logic [31:0] base;
      logic [23:0] len;
      logic        loop;
      int          dly;
      int          nwr;
      int          slot0;
      int          nclr;
      logic [31:0] clr0;
      int          ndone;
      logic        busy;
      logic [15:0] und;
   } vec_t;

   vec_t        tbl[8];
   int          ncmp = 0, nerr = 0;
   int          cyc = 0, ack_dly = 0, wait_cnt = 0, stab_err = 0;
   int          nwr = 0, nclr = 0, ndone = 0;
   logic [9:0]  wr_addr[64];
   logic [31:0] wr_data[64];
   int          wr_cyc[64];
   logic [31:0] clr_mask[8];
   int          clr_cyc[8];
   logic        prev_req = 1'b0, prev_ack = 1'b0;
   logic [31:0] prev_addr = 32'h0;

   function automatic logic [31:0] mword(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: sample DUT outputs on the falling edge, update bus models, drive the ack.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (rst_n && prev_req && !prev_ack && (!mem_req || mem_addr != prev_addr)) stab_err++;
      if (aud_write_mask == 32'hFFFF_FFFF) begin
         if (nwr < 64) begin
            wr_addr[nwr] = aud_addr;
            wr_data[nwr] = aud_data_in;
            wr_cyc[nwr]  = cyc;
         end
         nwr++;
      end else if (aud_addr == 10'h0 && aud_write_mask != 32'h0) begin
         if (nclr < 8) begin
            clr_mask[nclr] = aud_write_mask;
            clr_cyc[nclr]  = cyc;
         end
         nclr++;
         status = status & ~aud_write_mask[1:0];
      end
      if (done_pulse) ndone++;
      prev_req  = mem_req;
      prev_addr = mem_addr;
      if (mem_req) begin
         if (wait_cnt >= ack_dly) begin
            mem_ack   = 1'b1;
            mem_rdata = mword(mem_addr);
            wait_cnt  = 0;
         end else begin
            mem_ack  = 1'b0;
            wait_cnt++;
         end
      end else begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end
      prev_ack = mem_ack;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; cfg_en = 1'b0; cfg_loop = 1'b0; status = 2'b00; ack_dly = 0;
      tick(); tick();
      nwr = 0; nclr = 0; ndone = 0; stab_err = 0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_nwr(input int n, input int budget);
      for (int k = 0; k < budget && nwr < n; k++) tick();
      chk("wait_writes", 64'(nwr), 64'(n));
   endtask

   initial begin
      rst_n = 1'b0; cfg_en = 1'b0; cfg_loop = 1'b0; cfg_base = 32'h0; cfg_len = 24'h0;
      mem_ack = 1'b0; mem_rdata = 32'h0; status = 2'b00;

      tbl[0] = '{2'b10, 32'h0000_1000, 24'd64, 1'b0, 0, 8, 8, 1, 32'h2, 0, 1'b1, 16'd0};
      tbl[1] = '{2'b01, 32'h0000_2000, 24'd64, 1'b0, 0, 8, 0, 1, 32'h1, 0, 1'b1, 16'd0};
      tbl[2] = '{2'b11, 32'h0000_3000, 24'd64, 1'b0, 0, 16, 8, 2, 32'h2, 0, 1'b1, 16'd1};
`ifdef AUDIO_DMA_SILENCE_EN
      tbl[3] = '{2'b10, 32'h0000_4000, 24'd4, 1'b0, 0, 8, 8, 1, 32'h2, 1, 1'b1, 16'd0};
`else
      tbl[3] = '{2'b10, 32'h0000_4000, 24'd4, 1'b0, 0, 4, 8, 1, 32'h2, 1, 1'b0, 16'd0};
`endif
      tbl[4] = '{2'b10, 32'h0000_5000, 24'd4, 1'b1, 0, 8, 8, 1, 32'h2, 0, 1'b1, 16'd0};
      tbl[5] = '{2'b01, 32'h0000_6002, 24'd64, 1'b0, 3, 8, 0, 1, 32'h1, 0, 1'b1, 16'd0};
      tbl[6] = '{2'b10, 32'hFFFF_FFF0, 24'd64, 1'b0, 1, 8, 8, 1, 32'h2, 0, 1'b1, 16'd0};
      tbl[7] = '{2'b10, 32'h0000_9000, 24'd0, 1'b0, 0, 0, 0, 0, 32'h0, 0, 1'b0, 16'd0};

      do_reset();
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_aud_addr", 64'(aud_addr), 64'd0);
      chk("rst_aud_mask", 64'(aud_write_mask), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_underrun", 64'(underrun_cnt), 64'd0);

      for (int r = 0; r < 8; r++) begin
         do_reset();
         cfg_base = tbl[r].base; cfg_len = tbl[r].len; cfg_loop = tbl[r].loop;
         ack_dly  = tbl[r].dly;  status  = tbl[r].st;  cfg_en   = 1'b1;
         repeat (150) tick();
         chk($sformatf("row%0d_nwr", r), 64'(nwr), 64'(tbl[r].nwr));
         for (int i = 0; i < tbl[r].nwr && i < nwr; i++) begin
            int          src;
            logic [31:0] exp_d;
            src   = tbl[r].loop ? i % int'(tbl[r].len) : i;
            exp_d = (!tbl[r].loop && i >= int'(tbl[r].len)) ? 32'h0
                    : mword((tbl[r].base & 32'hFFFF_FFFC) + 32'(4 * src));
            chk($sformatf("row%0d_wr%0d_addr", r, i), 64'(wr_addr[i]),
                64'(10'h200 + 10'((tbl[r].slot0 + i) % 16)));
            chk($sformatf("row%0d_wr%0d_data", r, i), 64'(wr_data[i]), 64'(exp_d));
         end
         chk($sformatf("row%0d_nclr", r), 64'(nclr), 64'(tbl[r].nclr));
         if (tbl[r].nclr > 0 && nclr > 0)
            chk($sformatf("row%0d_clr_mask", r), 64'(clr_mask[0]), 64'(tbl[r].clr0));
         chk($sformatf("row%0d_done", r), 64'(ndone), 64'(tbl[r].ndone));
         chk($sformatf("row%0d_busy", r), 64'(busy), 64'(tbl[r].busy));
         chk($sformatf("row%0d_underrun", r), 64'(underrun_cnt), 64'(tbl[r].und));
         chk($sformatf("row%0d_req_stable", r), 64'(stab_err), 64'd0);
         if (tbl[r].dly == 0 && (tbl[r].loop || tbl[r].len >= 24'd8) && nwr >= 8 && nclr > 0)
            chk($sformatf("row%0d_half_cycles", r), 64'(wr_cyc[7] - clr_cyc[0]), 64'd16);
      end

      // Lower half first, then upper: slot order and source addresses run on without a gap.
      do_reset();
      cfg_base = 32'h0000_7000; cfg_len = 24'd64; cfg_loop = 1'b0; status = 2'b01; cfg_en = 1'b1;
      wait_nwr(8, 100);
      status = 2'b10;
      wait_nwr(16, 100);
      for (int i = 0; i < 16 && i < nwr; i++) begin
         chk($sformatf("seq_lo_hi_addr%0d", i), 64'(wr_addr[i]), 64'(10'h200 + 10'(i)));
         chk($sformatf("seq_lo_hi_data%0d", i), 64'(wr_data[i]), 64'(mword(32'h7000 + 32'(4 * i))));
      end

      // Slow memory with cfg_en dropped mid-half: the half still completes, then the engine parks.
      do_reset();
      cfg_base = 32'h0000_8000; cfg_len = 24'd64; ack_dly = 5; status = 2'b10; cfg_en = 1'b1;
      wait_nwr(3, 200);
      cfg_en = 1'b0;
      wait_nwr(8, 200);
      repeat (10) tick();
      chk("slow_nwr_final", 64'(nwr), 64'd8);
      chk("slow_last_addr", 64'(wr_addr[7]), 64'h20F);
      chk("slow_last_data", 64'(wr_data[7]), 64'(mword(32'h801C)));
      chk("slow_busy", 64'(busy), 64'd0);
      chk("slow_req_stable", 64'(stab_err), 64'd0);

      // Reset asserted while a fetch is outstanding clears every output without a clock edge.
      status = 2'b01; cfg_en = 1'b1;
      for (int k = 0; k < 50 && !mem_req; k++) tick();
      chk("fetch_seen", 64'(mem_req), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_mem_req", 64'(mem_req), 64'd0);
      chk("async_mem_addr", 64'(mem_addr), 64'd0);
      chk("async_aud_addr", 64'(aud_addr), 64'd0);
      chk("async_aud_data", 64'(aud_data_in), 64'd0);
      chk("async_aud_mask", 64'(aud_write_mask), 64'd0);
      chk("async_busy", 64'(busy), 64'd0);
      chk("async_done", 64'(done_pulse), 64'd0);
      rst_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
